// File: rtl/apb_register_adapter.sv
// ============================================================================
// apb_register_adapter
//
// Bridges an APB slave port onto a simple strobed register map. Each APB
// transfer is accepted in the first ACCESS cycle, produces a single one-clock
// write or read strobe for the addressed word, and completes with pready on
// the third ACCESS cycle. This gives two wait states for every transfer.
//
// Read strobes are intended to pop FIFO-style registers. The read data
// returned on prdata is the value the register map presented before the pop.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   psel      in   APB select
//   penable   in   APB access phase
//   pwrite    in   1 = write, 0 = read
//   paddr     in   [ADDR_W]  byte address; word index = paddr[ADDR_W-1:2]
//   pwdata    in   [32]      write data
//   prdata    out  [32]      read data, valid while pready = 1, else 0
//   pready    out            one-clock transfer-complete response
//   pslverr   out            error response for out-of-range word indices
//   write_en  out  [NREGS]   one-hot register write strobe
//   read_en   out  [NREGS]   one-hot register read strobe (FIFO pop)
//   data_in   out  [32]      write data to the register map
//   data_out  in   [NREGS][32] per-register read data from the register map
//
// Configuration macro:
//   APB_REGISTER_ADAPTER_SLVERR_EN  when defined, pslverr = 1 in the response
//                                   cycle of an access with index >= REGS.
//                                   When undefined, pslverr is always 0 and
//                                   such accesses complete silently.
//
// ADDR_W must be >= 2 + $clog2(NREGS).
// ============================================================================
module apb_register_adapter #(
    parameter int REGS   = 5,
    parameter int NREGS  = 2**$clog2(REGS),
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic [31:0]            pwdata,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [NREGS-1:0]       write_en,
    output logic [NREGS-1:0]       read_en,
    output logic [31:0]            data_in,
    input  logic [NREGS-1:0][31:0] data_out
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    // One extra bit so that REGS == 2**IDX_W does not wrap to zero.
    localparam logic [IDX_W:0] REGS_LIMIT = (IDX_W + 1)'(REGS);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;

    logic [IDX_W-1:0] req_idx;
    logic             req_in_range;
    logic [NREGS-1:0] req_onehot;
    logic             cur_in_range;
    logic [31:0]      cur_rdata;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic unused_paddr_lsbs;
    assign unused_paddr_lsbs = ^paddr[1:0];

    // Decode of the incoming request (used on the accept edge) and of the
    // captured index (used on the edge leaving STROBE).
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        req_idx      = paddr[ADDR_W-1:2];
        req_in_range = ({1'b0, req_idx} < REGS_LIMIT);
        req_onehot   = '0;
        if (req_in_range) begin
            req_onehot[req_idx[SEL_W-1:0]] = 1'b1;
        end

        cur_in_range = ({1'b0, idx_q} < REGS_LIMIT);
        cur_rdata    = '0;
        if (cur_in_range) begin
            cur_rdata = data_out[idx_q[SEL_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            write_en <= '0;
            read_en  <= '0;
            data_in  <= '0;
        end else begin
            // NOTE: non-blocking assignments let the pulse outputs default to
            // zero every cycle; a later assignment in the same block wins, so
            // each strobe and pready stay high for exactly one clock.
            write_en <= '0;
            read_en  <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;

            case (state)
                IDLE: begin
                    if (psel && penable) begin
                        state   <= STROBE;
                        idx_q   <= req_idx;
                        write_q <= pwrite;
                        data_in <= pwdata;
                        if (pwrite) begin
                            write_en <= req_onehot;
                        end else begin
                            read_en <= req_onehot;
                        end
                    end
                end

                STROBE: begin
                    // Unconditional: the transfer completes even if psel drops.
                    // data_out is sampled on the same edge the pop takes
                    // effect, so the pre-pop value is captured.
                    state  <= RESP;
                    pready <= 1'b1;
                    prdata <= write_q ? 32'h0 : cur_rdata;
`ifdef APB_REGISTER_ADAPTER_SLVERR_EN
                    pslverr <= !cur_in_range;
`else
                    pslverr <= 1'b0;
`endif
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_register_adapter.sv
// ============================================================================
// tb_apb_register_adapter
//
// Directed bench for apb_register_adapter. A transaction-level model records,
// for each accepted transfer, the cycle at which its strobe and response must
// appear and what they must contain; a per-cycle compare process checks every
// DUT output against that schedule. The bench also emulates a FIFO-style
// register map, where a read strobe bumps the register value on the following
// edge. Literal expectations pin the worked examples.
// ============================================================================
module tb_apb_register_adapter;

    localparam int REGS   = 5;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 8;

`ifdef APB_REGISTER_ADAPTER_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [31:0]            pwdata;
    logic [31:0]            prdata;
    logic                   pready;
    logic                   pslverr;
    logic [NREGS-1:0]       write_en;
    logic [NREGS-1:0]       read_en;
    logic [31:0]            data_in;
    logic [NREGS-1:0][31:0] dout;

    apb_register_adapter #(
        .REGS   (REGS),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register map emulation: read strobe pops the register (value + 0x100).
    function automatic logic [31:0] init_val(input int i);
        case (i)
            2:       return 32'h0000_07F9;
            4:       return 32'h0000_00A5;
            5, 6, 7: return 32'hDEAD_BEE0 + 32'(i);
            default: return 32'h1111_0000 + 32'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!reset)          dout[i] <= init_val(i);
            else if (read_en[i]) dout[i] <= dout[i] + 32'h100;
        end
    end

    // Transaction-level model: one scheduled transfer at a time.
    int          m_strobe  = -1;
    int          m_resp    = -1;
    int          m_din_cyc = 0;
    int          m_idx     = 0;
    bit          m_wr      = 1'b0;
    bit          m_inr     = 1'b0;
    logic [31:0] m_rdata   = '0;
    logic [31:0] m_din_old = '0;
    logic [31:0] m_din_new = '0;

    // Strobe monitor.
    int         wr_cnt [NREGS];
    int         rd_cnt [NREGS];
    int         pulses = 0;
    logic [7:0] last_we = '0;
    logic [7:0] last_re = '0;

    logic [7:0]  e_we, e_re;
    logic [31:0] e_prdata, e_din;
    logic        e_pready, e_err;

    always @(negedge clk) begin
        if (check_en) begin
            e_we     = (cyc == m_strobe && m_wr && m_inr)  ? (8'h1 << m_idx) : 8'h0;
            e_re     = (cyc == m_strobe && !m_wr && m_inr) ? (8'h1 << m_idx) : 8'h0;
            e_pready = (cyc == m_resp);
            e_prdata = (cyc == m_resp && !m_wr && m_inr) ? m_rdata : 32'h0;
            e_err    = (cyc == m_resp) && !m_inr && SLVERR;
            e_din    = (cyc >= m_din_cyc) ? m_din_new : m_din_old;
            check("cyc_write_en", 32'(write_en), 32'(e_we));
            check("cyc_read_en",  32'(read_en),  32'(e_re));
            check("cyc_pready",   32'(pready),   32'(e_pready));
            check("cyc_prdata",   prdata,        e_prdata);
            check("cyc_pslverr",  32'(pslverr),  32'(e_err));
            check("cyc_data_in",  data_in,       e_din);
        end
        for (int i = 0; i < NREGS; i++) begin
            if (write_en[i] === 1'b1) begin wr_cnt[i]++; pulses++; end
            if (read_en[i]  === 1'b1) begin rd_cnt[i]++; pulses++; end
        end
        if (write_en != '0) last_we = write_en;
        if (read_en  != '0) last_re = read_en;
    end

    // Schedules the model for a transfer whose first ACCESS cycle is now.
    task automatic model_accept(input bit wr, input logic [7:0] addr, input logic [31:0] wd);
        m_din_old = m_din_new;
        m_din_new = wd;
        m_din_cyc = cyc + 1;
        m_wr      = wr;
        m_idx     = int'(addr[7:2]);
        m_inr     = (m_idx < REGS);
        m_rdata   = m_inr ? dout[m_idx] : 32'h0;
        m_strobe  = cyc + 1;
        m_resp    = cyc + 2;
    endtask

    // One APB transfer: SETUP, then ACCESS held until pready (bounded).
    // lat is the ACCESS cycle number on which pready was seen (0 = timeout).
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        model_accept(wr, addr, wd);
        lat = 0; rd = '0; err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (pready === 1'b1) begin
                lat = k; rd = prdata; err = pslverr;
                break;
            end
        end
        check("latency", 32'(lat), 32'd3);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          p0;

    initial begin
        for (int i = 0; i < NREGS; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; end
        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",   32'(pready),   32'h0);
        check("rst_pslverr",  32'(pslverr),  32'h0);
        check("rst_prdata",   prdata,        32'h0);
        check("rst_write_en", 32'(write_en), 32'h0);
        check("rst_read_en",  32'(read_en),  32'h0);
        check("rst_data_in",  data_in,       32'h0);
        reset = 1'b1;
        check_en = 1'b1;

        // psel low in IDLE: nothing happens.
        idle(4);

        // Write word 0.
        xfer(1'b1, 8'h00, 32'h1234_5678, rd, err, lat);
        check("w0_pslverr", 32'(err), 32'h0);
        check("w0_data_in", data_in, 32'h1234_5678);
        check("w0_strobe",  32'(last_we), 32'h01);
        check("w0_count",   32'(wr_cnt[0]), 32'd1);
        idle(2);

        // Read word 4 (0xA5).
        xfer(1'b0, 8'h10, 32'h0, rd, err, lat);
        check("r4_prdata", rd, 32'h0000_00A5);
        check("r4_strobe", 32'(last_re), 32'h10);
        check("r4_count",  32'(rd_cnt[4]), 32'd1);
        idle(1);

        // Back-to-back: write word 1 then read word 2.
        xfer(1'b1, 8'h04, 32'hCAFE_0001, rd, err, lat);
        xfer(1'b0, 8'h08, 32'h0, rd, err, lat);
        check("b2b_prdata",  rd, 32'h0000_07F9);
        check("b2b_wr_cnt1", 32'(wr_cnt[1]), 32'd1);
        check("b2b_rd_cnt2", 32'(rd_cnt[2]), 32'd1);
        idle(1);

        // Out-of-range accesses: no strobe, prdata 0, pslverr per build.
        p0 = pulses;
        xfer(1'b0, 8'h18, 32'h0, rd, err, lat);
        check("oor6_prdata",  rd, 32'h0);
        check("oor6_pslverr", 32'(err), 32'(SLVERR));
        xfer(1'b0, 8'h14, 32'h0, rd, err, lat);
        check("oor5_prdata",  rd, 32'h0);
        xfer(1'b1, 8'hFC, 32'h0BAD_F00D, rd, err, lat);
        check("oor63_pslverr", 32'(err), 32'(SLVERR));
        check("oor63_data_in", data_in, 32'h0BAD_F00D);
        check("oor_no_pulse",  32'(pulses - p0), 32'd0);
        idle(2);

        // Second read of word 4 sees the earlier pop.
        xfer(1'b0, 8'h10, 32'h0, rd, err, lat);
        check("r4_after_pop", rd, 32'h0000_01A5);
        idle(1);

        // Sweep of in-range words: write then read each.
        for (int i = 0; i < REGS; i++) begin
            xfer(1'b1, 8'(i * 4), 32'hA000_0000 + 32'(i), rd, err, lat);
            xfer(1'b0, 8'(i * 4), 32'h5555_0000, rd, err, lat);
            check("sweep_prdata", rd, m_rdata);
        end
        idle(2);

        // Reset asserted in the STROBE cycle aborts the transfer.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h0000_0055;
        @(posedge clk); #1;
        penable = 1'b1;
        model_accept(1'b1, 8'h0C, 32'h0000_0055);
        @(posedge clk); #1;
        check("abort_strobe_seen", 32'(write_en), 32'h08);
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        m_strobe = -1; m_resp = -1; m_din_old = '0; m_din_new = '0;
        check("abort_write_en", 32'(write_en), 32'h0);
        check("abort_pready",   32'(pready),   32'h0);
        check("abort_data_in",  data_in,       32'h0);
        reset = 1'b1;
        idle(3);

        // A normal write afterwards completes.
        xfer(1'b1, 8'h04, 32'h0F0F_1234, rd, err, lat);
        check("post_rst_pslverr", 32'(err), 32'h0);
        check("post_rst_wr_cnt1", 32'(wr_cnt[1]), 32'd3);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_register_adapter.md
APB_REGISTER_ADAPTER -- requirements
Module: apb_register_adapter

Interface
REQ-001 Parameter REGS, default 5: number of implemented registers.
REQ-002 Parameter NREGS, default 2**$clog2(REGS) (8 for REGS=5): width of the strobe vectors and the depth of the read-data array.
REQ-003 Parameter ADDR_W, default 8: APB byte-address width; ADDR_W SHALL be >= 2+$clog2(NREGS).
REQ-004 Ports, each given as name, direction, width, meaning:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address; word index = paddr[ADDR_W-1:2].
- pwdata  in  32  write data.
- prdata  out  32  read data, valid while pready=1.
- pready  out  1  transfer-complete response.
- pslverr  out  1  error response.
- write_en  out  NREGS  one-hot register write strobe.
- read_en  out  NREGS  one-hot register read strobe (FIFO pop).
- data_in  out  32  write data to the register map.
- data_out  in  NREGS x 32  per-register read data from the register map.

Function
REQ-005 FSM states SHALL be IDLE, STROBE and RESP; all outputs SHALL be registered.
REQ-006 IDLE -> STROBE SHALL occur when psel=1 and penable=1; on that edge idx=paddr[ADDR_W-1:2], pwrite and pwdata are captured, and data_in is updated to pwdata.
REQ-007 In STROBE, exactly one bit write_en[idx] (write) or read_en[idx] (read) SHALL be high for exactly one clk; all other strobe bits SHALL be 0.
REQ-008 On the edge leaving STROBE, the read-data register SHALL capture data_out[idx]; this is the value present before the pop takes effect.
REQ-009 STROBE SHALL always go to RESP, even if psel drops.
REQ-010 In RESP, pready SHALL be 1 for exactly one clk, with prdata equal to the captured value for reads and 0 for writes; RESP SHALL then go to IDLE.
REQ-011 Latency: pready SHALL assert on the third ACCESS cycle, giving two wait states for every transfer.
REQ-012 The adapter SHALL NOT start a new transfer in the cycle after RESP unless psel=1 and penable=1 are presented again.
REQ-013 Back-to-back transfers (SETUP immediately after RESP) SHALL each produce exactly one strobe.
REQ-014 If idx >= REGS, no strobe SHALL assert, prdata SHALL be 0, and STROBE/RESP timing SHALL be unchanged.
REQ-015 If psel=0 while in IDLE, the FSM SHALL remain in IDLE with all strobes 0.
REQ-016 Outside RESP, prdata SHALL hold 0 and pready SHALL be 0.

Reset
REQ-017 While reset=0, on a clock edge the state SHALL become IDLE and pready, pslverr, prdata, write_en, read_en and data_in SHALL all become 0.
REQ-018 A reset asserted in STROBE or RESP SHALL abort the transfer: strobes are deasserted on the reset edge, and no pready is issued for that transfer.

Configuration
REQ-019 Macro APB_REGISTER_ADAPTER_SLVERR_EN SHALL control the error response.
- Defined: pslverr=1 in RESP when idx >= REGS, else 0.
- Undefined: pslverr SHALL be constant 0, and out-of-range accesses SHALL complete silently with prdata=0.

Verification
REQ-020 Write paddr=0x00, pwdata=0x1234_5678 -> data_in=0x1234_5678; write_en=8'b0000_0001 for 1 clk; pready on the 3rd ACCESS cycle; pslverr=0.
REQ-021 Read paddr=0x10 with data_out[4]=0x0000_00A5 -> read_en=8'b0001_0000 for 1 clk; prdata=0x0000_00A5 with pready.
REQ-022 Write at 0x04 followed immediately by read at 0x08 (data_out[2]=0x7F9) -> exactly one write_en[1] pulse, then one read_en[2] pulse; prdata=0x7F9.
REQ-023 Read paddr=0x18 (idx 6 >= REGS) -> no strobe; prdata=0; pslverr=1 with the macro defined, 0 without it.
REQ-024 Assert reset=0 in the STROBE cycle -> next edge: all strobes 0, state IDLE, no pready; a following write at 0x04 completes normally.
